tx_line_framer: RTL



---
 rtl/tx_line_framer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/tx_line_framer.sv
// tx_line_framer: serialises AXI4-Stream video lines into sync, line number, pixel bytes and XOR checksum.
// Optional macro TX_LINE_FRAMER_PIXCNT_EN adds a 16-bit pixel-count field before the checksum.
module tx_line_framer #(
  parameter logic [7:0] SOF_SYNC = 8'hA5,
  parameter logic [7:0] SOL_SYNC = 8'h5A,
  parameter int         LINE_W   = 12
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] s_axis_video_tdata,
  input  logic        s_axis_video_tvalid,
  output logic        s_axis_video_tready,
  input  logic        s_axis_video_tlast,
  input  logic        s_axis_video_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        sof_err
);
  typedef enum logic [3:0] {IDLE, SYNC, HDR_L, HDR_H, LOAD, PIX3, PIX2, PIX1, PIX0, CNT_L, CNT_H, CHK} state_t;
  state_t state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [31:0] pix_q, pix_d;
  logic [15:0] line16;
  logic [7:0] chk_q, chk_d, tdata_q, tdata_d;
  logic peek_q, peek_d, last_q, last_d, first_q, first_d, err_q, err_d;
  logic tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d, acc, cap;
`ifdef TX_LINE_FRAMER_PIXCNT_EN
  logic [15:0] cnt_q, cnt_d;
`endif
  assign s_axis_video_tready = state_q == LOAD;
  assign m_axis_tdata = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast = tlast_q;
  assign m_axis_tuser = tuser_q;
  assign sof_err = err_q;
  always_comb begin
    acc = tvalid_q && m_axis_tready;
    cap = s_axis_video_tvalid && state_q == LOAD;
    state_d = state_q;
    line_d = line_q;
    peek_d = peek_q;
    pix_d = pix_q;
    last_d = last_q;
    first_d = first_q;
    err_d = err_q;
    chk_d = state_q == SYNC ? 8'h00 : (acc && state_q inside {[HDR_L:CNT_H]}) ? chk_q ^ tdata_q : chk_q;
`ifdef TX_LINE_FRAMER_PIXCNT_EN
    cnt_d = state_q == SYNC ? 16'h0 : (cap && cnt_q != 16'hFFFF) ? cnt_q + 16'h1 : cnt_q;
`endif
    case (state_q)
      IDLE: if (s_axis_video_tvalid) begin
        peek_d = s_axis_video_tuser;
        line_d = s_axis_video_tuser ? '0 : line_q;
        state_d = SYNC;
      end
      LOAD: if (cap) begin
        pix_d = s_axis_video_tdata;
        last_d = s_axis_video_tlast;
        first_d = 1'b0;
        err_d = err_q | (s_axis_video_tuser & ~first_q);
        state_d = PIX3;
      end
`ifdef TX_LINE_FRAMER_PIXCNT_EN
      PIX0: if (acc) state_d = last_q ? CNT_L : LOAD;
`else
      PIX0: if (acc) state_d = last_q ? CHK : LOAD;
`endif
      CHK: if (acc) begin
        line_d = line_q + LINE_W'(1);
        state_d = IDLE;
      end
      default: begin
        first_d = state_q == HDR_H ? 1'b1 : first_q;
        state_d = acc ? state_t'(state_q + 4'd1) : state_q;
      end
    endcase
    line16 = 16'(line_d);
    tvalid_d = !(state_d inside {IDLE, LOAD});
    tlast_d = state_d == CHK;
    tuser_d = state_d == SYNC && peek_d;
    case (state_d)
      SYNC:  tdata_d = peek_d ? SOF_SYNC : SOL_SYNC;
      HDR_L: tdata_d = line16[7:0];
      HDR_H: tdata_d = line16[15:8];
      PIX3:  tdata_d = pix_d[31:24];
      PIX2:  tdata_d = pix_d[23:16];
      PIX1:  tdata_d = pix_d[15:8];
      PIX0:  tdata_d = pix_d[7:0];
`ifdef TX_LINE_FRAMER_PIXCNT_EN
      CNT_L: tdata_d = cnt_d[7:0];
      CNT_H: tdata_d = cnt_d[15:8];
`endif
      CHK:   tdata_d = chk_d;
      default: tdata_d = 8'h00;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      line_q <= '0;
      pix_q <= '0;
      chk_q <= '0;
      peek_q <= 1'b0;
      last_q <= 1'b0;
      first_q <= 1'b0;
      err_q <= 1'b0;
      tdata_q <= '0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      tuser_q <= 1'b0;
`ifdef TX_LINE_FRAMER_PIXCNT_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      line_q <= line_d;
      pix_q <= pix_d;
      chk_q <= chk_d;
      peek_q <= peek_d;
      last_q <= last_d;
      first_q <= first_d;
      err_q <= err_d;
      tdata_q <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q <= tlast_d;
      tuser_q <= tuser_d;
`ifdef TX_LINE_FRAMER_PIXCNT_EN
      cnt_q <= cnt_d;
`endif
    end
  end
endmodule
